cordic_vec_iter: RTL and testbench



---
 rtl/cordic_vec_iter.sv | 199 +++++++++++++++++++
 tb/tb_cordic_vec_iter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_vec_iter.sv
// Iterative CORDIC vectoring engine: one micro-rotation per clock. Returns the
// gain-scaled magnitude (x * K, uncompensated) and atan2(y, x) of the input vector.
module cordic_vec_iter #(
  parameter int unsigned CORDIC_WIDTH = 22,
  parameter int unsigned ANGLE_WIDTH  = 22,
  parameter int unsigned N_ITER       = 16
) (
  input  logic                    clk,
  input  logic                    nreset,
  input  logic [CORDIC_WIDTH-1:0] x_in,
  input  logic [CORDIC_WIDTH-1:0] y_in,
  input  logic                    enable,
  output logic [CORDIC_WIDTH+1:0] x_out,
  output logic [ANGLE_WIDTH-1:0]  z_out,
  output logic                    op_vld,
  output logic                    busy
);

  localparam int unsigned DW = CORDIC_WIDTH + 2;
  localparam int unsigned IW = (N_ITER > 1) ? $clog2(N_ITER) : 1;
  localparam logic [IW-1:0] LastIter = IW'(N_ITER - 1);

  // +pi/2 in angle units (2^(ANGLE_WIDTH-1) LSB = pi)
  localparam logic [ANGLE_WIDTH-1:0] HalfPi = {2'b01, {(ANGLE_WIDTH-2){1'b0}}};

  // The arctangent table is held at 22-bit angle scale; other widths rescale it.
  localparam int unsigned AngShl = (ANGLE_WIDTH >= 22) ? ANGLE_WIDTH - 22 : 0;
  localparam int unsigned AngShr = (ANGLE_WIDTH < 22) ? 22 - ANGLE_WIDTH : 0;
  localparam logic [63:0] AngRnd = (AngShr > 0) ? (64'd1 << (AngShr - 1)) : 64'd0;

  typedef enum logic [1:0] {StIdle, StRot, StDone} state_e;

  state_e                  state_q, state_d;
  logic [IW-1:0]           iter_q, iter_d;
  logic signed [DW-1:0]    x_q, x_d, y_q, y_d;
  logic [ANGLE_WIDTH-1:0]  z_q, z_d;
  logic                    zero_q, zero_d;
  logic signed [DW-1:0]    x_out_q, x_out_d;
  logic [ANGLE_WIDTH-1:0]  z_out_q, z_out_d;
  logic                    op_vld_q, op_vld_d;
  logic                    busy_q, busy_d;

  logic signed [DW-1:0]    x_ext, y_ext, x_pre, y_pre;
  logic [ANGLE_WIDTH-1:0]  z_pre;
  logic signed [DW-1:0]    x_sh, y_sh, x_rot, y_rot;
  logic [ANGLE_WIDTH-1:0]  z_rot, a_i;

  // atan(2^-i) scaled so that 2^21 = pi, rounded to nearest
  function automatic logic [ANGLE_WIDTH-1:0] angle_lut(input int unsigned idx);
    logic [63:0] base;
    logic [63:0] scaled;
    case (idx)
      0:       base = 64'd524288;
      1:       base = 64'd309506;
      2:       base = 64'd163534;
      3:       base = 64'd83012;
      4:       base = 64'd41667;
      5:       base = 64'd20854;
      6:       base = 64'd10430;
      7:       base = 64'd5215;
      8:       base = 64'd2608;
      9:       base = 64'd1304;
      10:      base = 64'd652;
      11:      base = 64'd326;
      12:      base = 64'd163;
      13:      base = 64'd81;
      14:      base = 64'd41;
      15:      base = 64'd20;
      16:      base = 64'd10;
      17:      base = 64'd5;
      18:      base = 64'd3;
      19:      base = 64'd1;
      20:      base = 64'd1;
      default: base = 64'd0;
    endcase
    scaled = ((base << AngShl) + AngRnd) >> AngShr;
    return scaled[ANGLE_WIDTH-1:0];
  endfunction

  assign x_ext = {{2{x_in[CORDIC_WIDTH-1]}}, x_in};
  assign y_ext = {{2{y_in[CORDIC_WIDTH-1]}}, y_in};

  // Pre-rotation by +/-pi/2 folds the left half-plane into the CORDIC convergence range
  always_comb begin
    x_pre = x_ext;
    y_pre = y_ext;
    z_pre = '0;
    if (x_ext[DW-1]) begin
      if (!y_ext[DW-1]) begin
        x_pre = y_ext;
        y_pre = -x_ext;
        z_pre = HalfPi;
      end else begin
        x_pre = -y_ext;
        y_pre = x_ext;
        z_pre = -HalfPi;
      end
    end
  end

  // One micro-rotation driving y toward zero; z wraps modulo 2^ANGLE_WIDTH
  always_comb begin
    x_sh = x_q >>> iter_q;
    y_sh = y_q >>> iter_q;
    a_i  = angle_lut(32'(iter_q));
    if (!y_q[DW-1]) begin
      x_rot = x_q + y_sh;
      y_rot = y_q - x_sh;
      z_rot = z_q + a_i;
    end else begin
      x_rot = x_q - y_sh;
      y_rot = y_q + x_sh;
      z_rot = z_q - a_i;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    iter_d   = iter_q;
    x_d      = x_q;
    y_d      = y_q;
    z_d      = z_q;
    zero_d   = zero_q;
    x_out_d  = x_out_q;
    z_out_d  = z_out_q;
    op_vld_d = 1'b0;
    busy_d   = busy_q;
    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d = StRot;
          iter_d  = '0;
          x_d     = x_pre;
          y_d     = y_pre;
          z_d     = z_pre;
          // y >= 0 steering would accumulate a bogus angle for a null vector
          zero_d  = (x_in == '0) && (y_in == '0);
          busy_d  = 1'b1;
        end
      end
      StRot: begin
        x_d = x_rot;
        y_d = y_rot;
        z_d = z_rot;
        if (iter_q == LastIter) begin
          state_d  = StDone;
          iter_d   = '0;
          x_out_d  = x_rot;
          z_out_d  = zero_q ? '0 : z_rot;
          op_vld_d = 1'b1;
        end else begin
          iter_d = iter_q + IW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q  <= StIdle;
      iter_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      zero_q   <= 1'b0;
      x_out_q  <= '0;
      z_out_q  <= '0;
      op_vld_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      iter_q   <= iter_d;
      x_q      <= x_d;
      y_q      <= y_d;
      z_q      <= z_d;
      zero_q   <= zero_d;
      x_out_q  <= x_out_d;
      z_out_q  <= z_out_d;
      op_vld_q <= op_vld_d;
      busy_q   <= busy_d;
    end
  end

  assign x_out  = x_out_q;
  assign z_out  = z_out_q;
  assign op_vld = op_vld_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_cordic_vec_iter.sv
// Directed bench for cordic_vec_iter: table of vectors with hand-computed
// magnitude/angle, plus handshake, enable-ignore and mid-rotation reset sequences.
module tb_cordic_vec_iter;

  logic        clk = 1'b0;
  logic        nreset;
  logic [21:0] x_in, y_in;
  logic        enable;
  logic [23:0] x_out;
  logic [21:0] z_out;
  logic        op_vld, busy;

  int total = 0;
  int bad   = 0;

  cordic_vec_iter #(
    .CORDIC_WIDTH(22),
    .ANGLE_WIDTH (22),
    .N_ITER      (16)
  ) dut (
    .clk   (clk),
    .nreset(nreset),
    .x_in  (x_in),
    .y_in  (y_in),
    .enable(enable),
    .x_out (x_out),
    .z_out (z_out),
    .op_vld(op_vld),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    x;
    int    y;
    int    ex;
    int    ez;
    int    tx;
    int    tz;
  } vec_t;

  vec_t vecs[11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input bit ok, input longint act, input longint exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int xo_val();
    return {{8{x_out[23]}}, x_out};
  endfunction

  function automatic int zo_val();
    return {{10{z_out[21]}}, z_out};
  endfunction

  // Angle difference folded modulo 2^22 so +pi and -pi compare equal
  function automatic int zdiff(input int a, input int b);
    logic [21:0] d;
    int          r;
    d = a[21:0] - b[21:0];
    r = {{10{d[21]}}, d};
    return (r < 0) ? -r : r;
  endfunction

  function automatic int iabs(input int a);
    return (a < 0) ? -a : a;
  endfunction

  // Start one operation and wait for its result; busy is counted over every sampled cycle
  task automatic run_op(input int x, input int y, output int lat, output int bsy,
                        output int xo, output int zo, output bit timeout);
    x_in   = x[21:0];
    y_in   = y[21:0];
    enable = 1'b1;
    step();
    enable  = 1'b0;
    lat     = 1;
    bsy     = busy ? 1 : 0;
    timeout = 1'b1;
    xo      = 0;
    zo      = 0;
    for (int k = 0; k < 100; k++) begin
      if (op_vld) begin
        timeout = 1'b0;
        break;
      end
      step();
      lat++;
      if (busy) bsy++;
    end
    xo = xo_val();
    zo = zo_val();
    step();
    if (busy) bsy++;
  endtask

  initial begin
    int lat, bsy, xo, zo, cnt, first, second;
    bit to;

    vecs[0]  = '{"pos_x",  1048576,  0,        1726749,  0,        864,  64};
    vecs[1]  = '{"pos_y",  0,        1048576,  1726749,  1048576,  864,  64};
    vecs[2]  = '{"diag",   1048576,  1048576,  2442024,  524288,   1221, 64};
    vecs[3]  = '{"neg_x", -1048576,  0,        1726749,  2097152,  864,  64};
    vecs[4]  = '{"q3",    -1048576, -1048576,  2442024, -1572864,  1221, 64};
    vecs[5]  = '{"zero",   0,        0,        0,        0,        0,    0};
    vecs[6]  = '{"q4",     1048576, -1048576,  2442024, -524288,   1221, 64};
    vecs[7]  = '{"neg_y",  0,       -1048576,  1726749, -1048576,  864,  64};
    vecs[8]  = '{"v345",   300000,   400000,   823380,   619011,   412,  64};
    vecs[9]  = '{"q2",    -400000,   300000,   823380,   1667587,  412,  64};
    vecs[10] = '{"min_x", -2097152,  0,        3453499,  2097152,  1727, 64};

    nreset = 1'b0;
    enable = 1'b0;
    x_in   = '0;
    y_in   = '0;
    #3;
    chk("rst_x_out",  x_out == '0, xo_val(), 0);
    chk("rst_z_out",  z_out == '0, zo_val(), 0);
    chk("rst_op_vld", op_vld == 1'b0, op_vld, 0);
    chk("rst_busy",   busy == 1'b0, busy, 0);
    step();
    step();
    nreset = 1'b1;
    step();

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].x, vecs[i].y, lat, bsy, xo, zo, to);
      chk({vecs[i].name, "_timeout"}, !to, to, 0);
      chk({vecs[i].name, "_latency"}, lat == 17, lat, 17);
      chk({vecs[i].name, "_x_out"}, iabs(xo - vecs[i].ex) <= vecs[i].tx, xo, vecs[i].ex);
      chk({vecs[i].name, "_z_out"}, zdiff(zo, vecs[i].ez) <= vecs[i].tz, zo, vecs[i].ez);
      if (i == 0) chk("busy_cycles", bsy == 17, bsy, 17);
    end

    // Results hold after the pulse
    step();
    chk("hold_x_out", iabs(xo_val() - 3453499) <= 1727, xo_val(), 3453499);
    chk("hold_z_out", zdiff(zo_val(), 2097152) <= 64, zo_val(), 2097152);

    // Enable held high through ROT and DONE with different operands must be ignored
    x_in   = 22'd300000;
    y_in   = 22'd400000;
    enable = 1'b1;
    step();
    x_in = 22'h300000;
    y_in = 22'h300000;
    to   = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (op_vld) begin
        to = 1'b0;
        break;
      end
      step();
    end
    chk("ign_timeout", !to, to, 0);
    chk("ign_z_out", zdiff(zo_val(), 619011) <= 64, zo_val(), 619011);
    step();
    enable = 1'b0;
    chk("ign_busy_after_done", busy == 1'b0, busy, 0);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (op_vld || busy) cnt++;
    end
    chk("ign_no_extra_op", cnt == 0, cnt, 0);

    // enable every cycle for 40 cycles
    cnt    = 0;
    first  = -1;
    second = -1;
    for (int k = 0; k < 40; k++) begin
      x_in   = 22'd1048576;
      y_in   = 22'd0;
      enable = 1'b1;
      step();
      if (op_vld) begin
        cnt++;
        if (first < 0) first = k;
        else if (second < 0) second = k;
      end
    end
    enable = 1'b0;
    chk("pulse_count", cnt == 2, cnt, 2);
    chk("pulse_spacing", (second - first) == 18, second - first, 18);
    to = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (!busy) begin
        to = 1'b0;
        break;
      end
      step();
    end
    chk("drain_timeout", !to, to, 0);
    step();

    // Reset during iteration 5
    x_in   = 22'd1048576;
    y_in   = 22'd1048576;
    enable = 1'b1;
    step();
    enable = 1'b0;
    for (int k = 0; k < 5; k++) step();
    chk("pre_rst_busy", busy == 1'b1, busy, 1);
    #2;
    nreset = 1'b0;
    #1;
    chk("mid_rst_x_out",  x_out == '0, xo_val(), 0);
    chk("mid_rst_z_out",  z_out == '0, zo_val(), 0);
    chk("mid_rst_op_vld", op_vld == 1'b0, op_vld, 0);
    chk("mid_rst_busy",   busy == 1'b0, busy, 0);
    step();
    nreset = 1'b1;
    cnt = 0;
    for (int k = 0; k < 25; k++) begin
      step();
      if (op_vld) cnt++;
    end
    chk("rst_no_op_vld", cnt == 0, cnt, 0);
    run_op(0, 1048576, lat, bsy, xo, zo, to);
    chk("post_rst_timeout", !to, to, 0);
    chk("post_rst_latency", lat == 17, lat, 17);
    chk("post_rst_x_out", iabs(xo - 1726749) <= 864, xo, 1726749);
    chk("post_rst_z_out", zdiff(zo, 1048576) <= 64, zo, 1048576);
    chk("post_rst_busy", bsy == 17, bsy, 17);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
